// File: rtl/led_array_scanner.sv
// Round-robin LED channel scanner: per-channel pattern registers behind a valid/ready
// write port, one-hot channel select with a blanking cycle at the start of every slot.
module led_array_scanner #(
    parameter int CHANNELS = 6,
    parameter int WIDTH    = 4,
    parameter int SLOT_LEN = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        scan_en,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [$clog2(CHANNELS)-1:0] wr_chan,
    input  logic [WIDTH-1:0]            wr_data,
    input  logic [CHANNELS-1:0]         en_a,
    input  logic [CHANNELS-1:0]         en_b,
    input  logic [CHANNELS-1:0]         en_c,
    output logic [CHANNELS-1:0]         led_sel,
    output logic [WIDTH-1:0]            led_data,
    output logic                        frame_start,
    output logic                        err_oor
);
    // state | meaning
    // IDLE  | scan parked, outputs dark
    // BLANK | one dark cycle, shadow pattern and gate latched for ch
    // DRIVE | SLOT_LEN-1 cycles showing the shadowed pattern of ch
    localparam int CH_W  = $clog2(CHANNELS);
    localparam int CNT_W = $clog2(SLOT_LEN);

    typedef enum logic [1:0] {S_IDLE, S_BLANK, S_DRIVE} state_t;

    state_t              state_q, state_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]    shadow_q, shadow_d;
    logic                gate_q, gate_d;
    logic [CHANNELS-1:0] sel_q, sel_d;
    logic [WIDTH-1:0]    data_q, data_d;
    logic                fs_q, fs_d;
    logic [WIDTH-1:0]    pat_q [CHANNELS];
    logic                wr_ready_q;
    logic                err_q;
    logic                wr_accept;
    logic                wr_oor;

    assign wr_accept = wr_valid & wr_ready_q;
    assign wr_oor    = (32'(wr_chan) >= 32'(CHANNELS));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            ch_q     <= '0;
            cnt_q    <= '0;
            shadow_q <= '0;
            gate_q   <= 1'b0;
            sel_q    <= '0;
            data_q   <= '0;
            fs_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            gate_q   <= gate_d;
            sel_q    <= sel_d;
            data_q   <= data_d;
            fs_q     <= fs_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        cnt_d   = cnt_q;
        if (!scan_en) begin
            state_d = S_IDLE;
            ch_d    = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_BLANK;
                    ch_d    = '0;
                    cnt_d   = '0;
                end
                S_BLANK: begin
                    state_d = S_DRIVE;
                    cnt_d   = '0;
                end
                S_DRIVE: begin
                    if (cnt_q == CNT_W'(SLOT_LEN - 2)) begin
                        state_d = S_BLANK;
                        cnt_d   = '0;
                        ch_d    = (ch_q == CH_W'(CHANNELS - 1)) ? '0 : ch_q + 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    ch_d    = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs are computed from the upcoming state so the registers line up with it;
    // a write landing on the BLANK edge is not seen by the shadow (old value wins).
    always_comb begin
        shadow_d = shadow_q;
        gate_d   = gate_q;
        if (state_q == S_BLANK) begin
            shadow_d = pat_q[ch_q];
            gate_d   = en_a[ch_q] & en_b[ch_q] & en_c[ch_q];
        end
        fs_d   = (state_d == S_BLANK) && (ch_d == '0);
        sel_d  = '0;
        data_d = '0;
        if (state_d == S_DRIVE && gate_d) begin
            sel_d  = CHANNELS'(1) << ch_d;
            data_d = shadow_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) pat_q[i] <= '0;
            wr_ready_q <= 1'b1;
            err_q      <= 1'b0;
        end else if (wr_accept) begin
            wr_ready_q <= 1'b0;
            if (wr_oor) err_q <= 1'b1;
            else        pat_q[wr_chan] <= wr_data;
        end else begin
            wr_ready_q <= 1'b1;
        end
    end

    assign wr_ready    = wr_ready_q;
    assign err_oor     = err_q;
    assign led_sel     = sel_q;
    assign led_data    = data_q;
    assign frame_start = fs_q;
endmodule

// File: tb/tb_led_array_scanner.sv
// Self-checking bench for led_array_scanner: per-slot expectations are queued from a
// bench-side pattern/enable model and compared as each scan slot is observed.
module tb_led_array_scanner;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scan_en = 1'b0;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [2:0] wr_chan = '0;
    logic [3:0] wr_data = '0;
    logic [5:0] en_a = '1, en_b = '1, en_c = '1;
    logic [5:0] led_sel;
    logic [3:0] led_data;
    logic       frame_start;
    logic       err_oor;

    led_array_scanner #(.CHANNELS(6), .WIDTH(4), .SLOT_LEN(16)) dut (
        .clk(clk), .rst(rst), .scan_en(scan_en),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_chan(wr_chan), .wr_data(wr_data),
        .en_a(en_a), .en_b(en_b), .en_c(en_c),
        .led_sel(led_sel), .led_data(led_data), .frame_start(frame_start), .err_oor(err_oor)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         ch;
        logic [5:0] sel;
        logic [3:0] data;
        logic       fs;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] pat_m [6];
    logic       en_m  [6];
    int         checks = 0;
    int         errors = 0;

    task automatic push_frame();
        exp_t e;
        for (int c = 0; c < 6; c++) begin
            e.ch   = c;
            e.fs   = (c == 0);
            e.sel  = en_m[c] ? 6'(1 << c) : 6'd0;
            e.data = en_m[c] ? pat_m[c] : 4'd0;
            exp_q.push_back(e);
        end
    endtask

    // Starts at a slot's blanking negedge, ends at the next slot's blanking negedge.
    task automatic observe_slot(output logic [5:0] sel, output logic [3:0] data,
                                output logic fs, output logic blank_ok, output logic stable);
        fs       = frame_start;
        blank_ok = (led_sel == 6'd0) && (led_data == 4'd0);
        @(negedge clk);
        sel    = led_sel;
        data   = led_data;
        stable = 1'b1;
        for (int i = 1; i < 15; i++) begin
            @(negedge clk);
            if (led_sel !== sel || led_data !== data || frame_start !== 1'b0) stable = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic wait_fs(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (frame_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic do_write(input logic [2:0] ch, input logic [3:0] d, output logic acc);
        wr_valid = 1'b1;
        wr_chan  = ch;
        wr_data  = d;
        acc      = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (wr_ready === 1'b1) begin
                @(negedge clk);
                acc = 1'b1;
                break;
            end
            @(negedge clk);
        end
        wr_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({led_sel, led_data, frame_start, err_oor, wr_ready} !== {6'd0, 4'd0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_outputs: got sel=%b data=%h fs=%b err=%b rdy=%b, expected 0/0/0/0/1",
                     led_sel, led_data, frame_start, err_oor, wr_ready);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write_scan();
        logic [3:0] init [6];
        logic acc, ok, fs, bok, st;
        logic [5:0] sel;
        logic [3:0] data;
        exp_t e;
        init = '{4'h1, 4'h3, 4'hA, 4'hF, 4'h7, 4'h9};
        for (int c = 0; c < 6; c++) begin
            do_write(3'(c), init[c], acc);
            pat_m[c] = init[c];
            en_m[c]  = 1'b1;
            checks++;
            if (acc !== 1'b1) begin
                errors++;
                $display("FAIL write_accept ch%0d: accepted=%b, expected 1", c, acc);
            end
        end
        scan_en = 1'b1;
        wait_fs(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL frame_start_timeout: got none, expected pulse"); end
        push_frame();
        for (int s = 0; s < 6; s++) begin
            observe_slot(sel, data, fs, bok, st);
            e = exp_q.pop_front();
            checks++;
            if ({bok, fs, sel, data, st} !== {1'b1, e.fs, e.sel, e.data, 1'b1}) begin
                errors++;
                $display("FAIL scan_slot ch%0d: got blank=%b fs=%b sel=%b data=%h stable=%b, expected fs=%b sel=%b data=%h",
                         e.ch, bok, fs, sel, data, st, e.fs, e.sel, e.data);
            end
        end
    endtask

    task automatic test_free_run();
        int cnt;
        logic fs, bok, st;
        logic [5:0] sel;
        logic [3:0] data;
        exp_t e;
        for (int f = 0; f < 3; f++) begin
            cnt = 0;
            do begin
                @(negedge clk);
                cnt++;
            end while (frame_start !== 1'b1 && cnt < 200);
            checks++;
            if (cnt != 96) begin
                errors++;
                $display("FAIL frame_period %0d: got %0d cycles, expected 96", f, cnt);
            end
        end
        push_frame();
        push_frame();
        for (int s = 0; s < 12; s++) begin
            observe_slot(sel, data, fs, bok, st);
            e = exp_q.pop_front();
            checks++;
            if ({bok, fs, sel, data, st} !== {1'b1, e.fs, e.sel, e.data, 1'b1}) begin
                errors++;
                $display("FAIL walk_slot %0d: got blank=%b fs=%b sel=%b data=%h stable=%b, expected fs=%b sel=%b data=%h",
                         s, bok, fs, sel, data, st, e.fs, e.sel, e.data);
            end
        end
    endtask

    task automatic test_gate();
        logic ok, fs, bok, st;
        logic [5:0] sel;
        logic [3:0] data;
        exp_t e;
        wait_fs(ok);
        en_b[3]  = 1'b0;
        en_m[3]  = 1'b0;
        push_frame();
        en_m[3]  = 1'b1;
        push_frame();
        for (int s = 0; s < 12; s++) begin
            if (s == 3) begin
                fork
                    observe_slot(sel, data, fs, bok, st);
                    begin
                        repeat (5) @(negedge clk);
                        en_b[3] = 1'b1;
                    end
                join
            end else begin
                observe_slot(sel, data, fs, bok, st);
            end
            e = exp_q.pop_front();
            checks++;
            if ({bok, fs, sel, data, st} !== {1'b1, e.fs, e.sel, e.data, 1'b1}) begin
                errors++;
                $display("FAIL gate_slot %0d ch%0d: got blank=%b fs=%b sel=%b data=%h stable=%b, expected fs=%b sel=%b data=%h",
                         s, e.ch, bok, fs, sel, data, st, e.fs, e.sel, e.data);
            end
        end
    endtask

    task automatic test_write_mid();
        logic ok, acc, fs, bok, st;
        logic [5:0] sel;
        logic [3:0] data;
        exp_t e;
        wait_fs(ok);
        push_frame();
        pat_m[1] = 4'h5;
        push_frame();
        for (int s = 0; s < 12; s++) begin
            if (s == 1) begin
                fork
                    observe_slot(sel, data, fs, bok, st);
                    begin
                        repeat (3) @(negedge clk);
                        do_write(3'd1, 4'h5, acc);
                        checks++;
                        if ({acc, wr_ready} !== 2'b10) begin
                            errors++;
                            $display("FAIL ready_drop: got acc=%b rdy=%b, expected acc=1 rdy=0", acc, wr_ready);
                        end
                        @(negedge clk);
                        checks++;
                        if (wr_ready !== 1'b1) begin
                            errors++;
                            $display("FAIL ready_restore: got %b, expected 1", wr_ready);
                        end
                    end
                join
            end else begin
                observe_slot(sel, data, fs, bok, st);
            end
            e = exp_q.pop_front();
            checks++;
            if ({bok, fs, sel, data, st} !== {1'b1, e.fs, e.sel, e.data, 1'b1}) begin
                errors++;
                $display("FAIL midwrite_slot %0d ch%0d: got blank=%b fs=%b sel=%b data=%h stable=%b, expected fs=%b sel=%b data=%h",
                         s, e.ch, bok, fs, sel, data, st, e.fs, e.sel, e.data);
            end
        end
    endtask

    task automatic test_oor();
        logic ok, acc, fs, bok, st;
        logic [5:0] sel;
        logic [3:0] data;
        exp_t e;
        do_write(3'd6, 4'hF, acc);
        checks++;
        if ({acc, wr_ready, err_oor} !== 3'b101) begin
            errors++;
            $display("FAIL oor_write: got acc=%b rdy=%b err=%b, expected 1/0/1", acc, wr_ready, err_oor);
        end
        wait_fs(ok);
        push_frame();
        for (int s = 0; s < 6; s++) begin
            observe_slot(sel, data, fs, bok, st);
            e = exp_q.pop_front();
            checks++;
            if ({bok, fs, sel, data, st} !== {1'b1, e.fs, e.sel, e.data, 1'b1}) begin
                errors++;
                $display("FAIL oor_slot ch%0d: got blank=%b fs=%b sel=%b data=%h stable=%b, expected fs=%b sel=%b data=%h",
                         e.ch, bok, fs, sel, data, st, e.fs, e.sel, e.data);
            end
        end
        checks++;
        if (err_oor !== 1'b1) begin
            errors++;
            $display("FAIL oor_sticky: got %b, expected 1", err_oor);
        end
    endtask

    task automatic test_abort();
        logic ok, fs, bok, st;
        logic [5:0] sel;
        logic [3:0] data;
        exp_t e;
        wait_fs(ok);
        push_frame();
        for (int s = 0; s < 4; s++) begin
            observe_slot(sel, data, fs, bok, st);
            e = exp_q.pop_front();
            checks++;
            if ({bok, fs, sel, data, st} !== {1'b1, e.fs, e.sel, e.data, 1'b1}) begin
                errors++;
                $display("FAIL preabort_slot ch%0d: got sel=%b data=%h, expected sel=%b data=%h",
                         e.ch, sel, data, e.sel, e.data);
            end
        end
        exp_q.delete();
        repeat (6) @(negedge clk);
        scan_en = 1'b0;
        @(negedge clk);
        checks++;
        if ({led_sel, led_data, frame_start} !== 11'd0) begin
            errors++;
            $display("FAIL abort_dark: got sel=%b data=%h fs=%b, expected all 0", led_sel, led_data, frame_start);
        end
        repeat (3) @(negedge clk);
        scan_en = 1'b1;
        @(negedge clk);
        checks++;
        if ({led_sel, led_data, frame_start} !== {6'd0, 4'd0, 1'b1}) begin
            errors++;
            $display("FAIL restart_blank: got sel=%b data=%h fs=%b, expected 0/0/1", led_sel, led_data, frame_start);
        end
        observe_slot(sel, data, fs, bok, st);
        checks++;
        if ({bok, fs, sel, data, st} !== {1'b1, 1'b1, 6'b000001, pat_m[0], 1'b1}) begin
            errors++;
            $display("FAIL restart_ch0: got sel=%b data=%h stable=%b, expected sel=000001 data=%h",
                     sel, data, st, pat_m[0]);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({led_sel, led_data, frame_start, err_oor, wr_ready} !== {6'd0, 4'd0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL async_reset: got sel=%b data=%h fs=%b err=%b rdy=%b, expected 0/0/0/0/1",
                     led_sel, led_data, frame_start, err_oor, wr_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) pat_m[c] = 4'h0;
        wait_fs(ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL post_reset_fs: got none, expected pulse"); end
        push_frame();
        for (int s = 0; s < 6; s++) begin
            observe_slot(sel, data, fs, bok, st);
            e = exp_q.pop_front();
            checks++;
            if ({bok, fs, sel, data, st} !== {1'b1, e.fs, e.sel, e.data, 1'b1}) begin
                errors++;
                $display("FAIL cleared_slot ch%0d: got sel=%b data=%h, expected sel=%b data=%h",
                         e.ch, sel, data, e.sel, e.data);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_scan();
        test_free_run();
        test_gate();
        test_write_mid();
        test_oor();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
